// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: NOP encoding, opcode field, fetch FSM states.
package pipeline_pkg;

  localparam int unsigned PC_WIDTH_DEF    = 16;
  localparam int unsigned INSTR_WIDTH_DEF = 16;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 10;

  localparam logic [5:0]  OPC_NOP  = 6'b000001;
  localparam logic [15:0] NOP_WORD = {OPC_NOP, 10'b0};

  typedef enum logic {
    RUN = 1'b0,
    IMM = 1'b1
  } fetch_state_e;

  function automatic logic [5:0] opcode_of(input logic [15:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter with redirect / hold / increment next-PC selection.
module pc_register #(
  parameter int unsigned          PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                redirect_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i,
  input  logic                hold_i,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic [PC_WIDTH-1:0] pc1_o
);

  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_next;
  logic [PC_WIDTH-1:0] w_pc1;

  // Wraps modulo 2^PC_WIDTH
  assign w_pc1 = r_pc + PC_WIDTH'(1);

  always_comb begin
    w_pc_next = w_pc1;
    if (redirect_i) begin
      w_pc_next = redirect_pc_i;
    end else if (hold_i) begin
      w_pc_next = r_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign pc_o  = r_pc;
  assign pc1_o = w_pc1;

endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID register; captures the LDM trailing immediate word.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned          PC_WIDTH    = PC_WIDTH_DEF,
  parameter int unsigned          INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [PC_WIDTH-1:0]    imem_addr_o,
  input  logic [INSTR_WIDTH-1:0] imem_data_i,
  input  logic                   stall_i,
  input  logic                   imm_flush_i,
  input  logic                   redirect_i,
  input  logic [PC_WIDTH-1:0]    redirect_pc_i,
  output logic [INSTR_WIDTH-1:0] if_id_instr_o,
  output logic [PC_WIDTH-1:0]    if_id_pc1_o,
  output logic                   if_id_valid_o,
  output logic [15:0]            imm_o,
  output logic                   imm_valid_o
);

  localparam logic [INSTR_WIDTH-1:0] BUBBLE = INSTR_WIDTH'(NOP_WORD);

  logic [PC_WIDTH-1:0]    w_pc;
  logic [PC_WIDTH-1:0]    w_pc1;
  logic                   w_pc_hold;

  fetch_state_e           r_state, w_state_d;
  logic [INSTR_WIDTH-1:0] r_instr, w_instr_d;
  logic [PC_WIDTH-1:0]    r_pc1, w_pc1_d;
  logic                   r_valid, w_valid_d;
  logic [15:0]            r_imm, w_imm_d;
  logic                   r_imm_valid, w_imm_valid_d;

  // Redirect overrides stall inside the PC register
  assign w_pc_hold = stall_i;

  pc_register #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .hold_i        (w_pc_hold),
    .pc_o          (w_pc),
    .pc1_o         (w_pc1)
  );

  always_comb begin
    w_state_d     = r_state;
    w_instr_d     = r_instr;
    w_pc1_d       = r_pc1;
    w_valid_d     = r_valid;
    w_imm_d       = r_imm;
    w_imm_valid_d = 1'b0;
    if (redirect_i) begin
      w_instr_d = BUBBLE;
      w_pc1_d   = '0;
      w_valid_d = 1'b0;
      w_state_d = RUN;
    end else if (!stall_i) begin
      unique case (r_state)
        RUN: begin
          if (imm_flush_i) begin
            w_imm_d   = 16'(imem_data_i);
            w_instr_d = BUBBLE;
            w_pc1_d   = '0;
            w_valid_d = 1'b0;
            w_state_d = IMM;
          end else begin
            w_instr_d = imem_data_i;
            w_pc1_d   = w_pc1;
            w_valid_d = 1'b1;
          end
        end
        IMM: begin
          // Decode holds a bubble here, so any flush request is spurious
          w_instr_d     = imem_data_i;
          w_pc1_d       = w_pc1;
          w_valid_d     = 1'b1;
          w_imm_valid_d = 1'b1;
          w_state_d     = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_instr     <= BUBBLE;
      r_pc1       <= '0;
      r_valid     <= 1'b0;
      r_imm       <= '0;
      r_imm_valid <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_instr     <= w_instr_d;
      r_pc1       <= w_pc1_d;
      r_valid     <= w_valid_d;
      r_imm       <= w_imm_d;
      r_imm_valid <= w_imm_valid_d;
    end
  end

  assign imem_addr_o   = w_pc;
  assign if_id_instr_o = r_instr;
  assign if_id_pc1_o   = r_pc1;
  assign if_id_valid_o = r_valid;
  assign imm_o         = r_imm;
  assign imm_valid_o   = r_imm_valid;

endmodule
